// File: rtl/jt5205_feeder.sv
// ADPCM nibble feeder for the MSM5205 core: streams packed bytes from ROM,
// high nibble first, with a one-byte prefetch buffer behind the playing byte.
module jt5205_feeder #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          irq,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [AW-1:0] eaddr_q, eaddr_d;
    logic [7:0]    cur_q, cur_d;
    logic [7:0]    nxt_q, nxt_d;
    logic          cur_v_q, cur_v_d;
    logic          nxt_v_q, nxt_v_d;
    logic          phase_hi_q, phase_hi_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic [3:0]    din_q, din_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            faddr_q    <= '0;
            eaddr_q    <= '0;
            cur_q      <= '0;
            nxt_q      <= '0;
            cur_v_q    <= 1'b0;
            nxt_v_q    <= 1'b0;
            phase_hi_q <= 1'b1;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            din_q      <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            faddr_q    <= faddr_d;
            eaddr_q    <= eaddr_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cur_v_q    <= cur_v_d;
            nxt_v_q    <= nxt_v_d;
            phase_hi_q <= phase_hi_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            din_q      <= din_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        faddr_d    = faddr_q;
        eaddr_d    = eaddr_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        cur_v_d    = cur_v_q;
        nxt_v_d    = nxt_v_q;
        phase_hi_d = phase_hi_q;
        last_d     = last_q;
        busy_d     = busy_q;
        din_d      = din_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        if (start) begin
            // A restart passes through HOLD so rom_cs is low for a cycle and a
            // stale rom_ok from the aborted request cannot be captured.
            state_d    = (state_q == IDLE) ? FETCH : HOLD;
            faddr_d    = start_addr;
            eaddr_d    = end_addr;
            cur_v_d    = 1'b0;
            nxt_v_d    = 1'b0;
            phase_hi_d = 1'b1;
            last_d     = 1'b0;
            busy_d     = 1'b1;
            din_d      = 4'd0;
        end else if (stop) begin
            state_d = IDLE;
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
            busy_d  = 1'b0;
            din_d   = 4'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (rom_ok) begin
                        if (!cur_v_q) begin
                            cur_d   = rom_data;
                            cur_v_d = 1'b1;
                        end else begin
                            nxt_d   = rom_data;
                            nxt_v_d = 1'b1;
                        end
                        last_d  = (faddr_q == eaddr_q);
                        faddr_d = faddr_q + 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!last_q && (!cur_v_q || !nxt_v_q)) state_d = FETCH;
                end
                default: ;
            endcase

            if (irq) begin
                if (!busy_q) begin
                    din_d = 4'd0;
                end else if (!cur_v_q) begin
                    din_d      = 4'd0;
                    underrun_d = 1'b1;
                end else if (phase_hi_q) begin
                    din_d      = cur_q[7:4];
                    phase_hi_d = 1'b0;
                end else begin
                    din_d      = cur_q[3:0];
                    phase_hi_d = 1'b1;
                    // Consume after any same-cycle capture so a byte landing in
                    // nxt while cur empties slides straight into cur.
                    if (nxt_v_d) begin
                        cur_d   = nxt_d;
                        nxt_v_d = 1'b0;
                    end else begin
                        cur_v_d = 1'b0;
                    end
                    if (last_q && !nxt_v_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    assign rom_cs    = (state_q == FETCH);
    assign rom_addr  = faddr_q;
    assign din       = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jt5205_feeder.sv
// Directed bench for jt5205_feeder: a latency-programmable ROM responder, a
// nibble scoreboard built from the ROM image, and a request-address log.
module tb_jt5205_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic        irq;
  logic [15:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [7:0]  rom_data;
  logic [3:0]  din;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [1:0]  dbg_state;

  jt5205_feeder #(.AW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .irq(irq),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .din(din), .busy(busy), .done(done), .underrun(underrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ROM model
  logic [7:0]  rom [0:65535];
  int          lat = 2;
  logic        inject_ok = 1'b0;
  int          wait_cnt = 0;

  initial begin
    rom_ok   = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clk);
      rom_ok = 1'b0;
      if (inject_ok) begin
        rom_ok   = 1'b1;
        rom_data = 8'hEE;
      end else if (rom_cs) begin
        if (wait_cnt >= lat - 1) begin
          rom_ok   = 1'b1;
          rom_data = rom[rom_addr];
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: request log and pulse counters
  logic [15:0] req_q[$];
  logic        cs_prev = 1'b0;
  int          done_cnt = 0;
  int          und_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rom_cs && !cs_prev) req_q.push_back(rom_addr);
      cs_prev = rom_cs;
      if (done) done_cnt++;
      if (underrun) und_cnt++;
    end
  end

  // scoreboard of expected nibbles
  logic [3:0] exp_q[$];

  task automatic load_exp(input logic [15:0] sa, input logic [15:0] ea);
    logic [15:0] a;
    exp_q.delete();
    a = sa;
    for (int i = 0; i < 65536; i++) begin
      exp_q.push_back(rom[a][7:4]);
      exp_q.push_back(rom[a][3:0]);
      if (a == ea) break;
      a = a + 16'd1;
    end
  endtask

  // driver tasks
  task automatic pulse_start(input logic [15:0] sa, input logic [15:0] ea);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pulse_irq();
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
  endtask

  // Issue irqs every `period` clocks until the scoreboard drains.
  task automatic drain(input int period, output int n_under);
    logic [3:0] e;
    int guard;
    n_under = 0;
    guard   = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      repeat (period - 1) @(negedge clk);
      pulse_irq();
      if (underrun) begin
        n_under++;
        check("din_starved", {28'd0, din}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("din_nibble", {28'd0, din}, {28'd0, e});
        check("done_pulse", {31'd0, done}, {31'd0, exp_q.size() == 0});
      end
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
    check("busy_after_end", {31'd0, busy}, 32'd0);
    repeat (period - 1) @(negedge clk);
    pulse_irq();
    check("din_after_end", {28'd0, din}, 32'd0);
    check("no_underrun_idle", {31'd0, underrun}, 32'd0);
  endtask

  task automatic check_reqs(input logic [15:0] sa, input int nbytes);
    logic [15:0] a;
    check("req_count", req_q.size(), nbytes);
    a = sa;
    for (int i = 0; i < nbytes && i < req_q.size(); i++) begin
      check("req_addr", {16'd0, req_q[i]}, {16'd0, a});
      a = a + 16'd1;
    end
  endtask

  int nu;

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'(i * 7 + 8'h13);
    rom[16'h0010] = 8'hA5;
    rom[16'h0020] = 8'h12; rom[16'h0021] = 8'h34;
    rom[16'h0022] = 8'h56; rom[16'h0023] = 8'h78;
    rom[16'h0030] = 8'h9B; rom[16'h0031] = 8'h2F; rom[16'h0032] = 8'hC4;
    rom[16'hFFFF] = 8'h3C; rom[16'h0000] = 8'hD1;
    rom[16'h0040] = 8'h9E; rom[16'h0041] = 8'h7A;
    rom[16'h0050] = 8'hC3;

    rst = 1'b1; start = 1'b0; stop = 1'b0; irq = 1'b0;
    start_addr = '0; end_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_din", {28'd0, din}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single byte
    lat = 2; load_exp(16'h0010, 16'h0010); req_q.delete();
    pulse_start(16'h0010, 16'h0010);
    check("single_busy", {31'd0, busy}, 32'd1);
    check("single_cs_latency", {31'd0, rom_cs}, 32'd1);
    drain(16, nu);
    check("single_underruns", nu, 0);
    check_reqs(16'h0010, 1);

    // four bytes
    lat = 3; load_exp(16'h0020, 16'h0023); req_q.delete(); und_cnt = 0;
    pulse_start(16'h0020, 16'h0023);
    drain(16, nu);
    check("four_underruns", und_cnt, 0);
    check_reqs(16'h0020, 4);

    // slow ROM
    lat = 40; load_exp(16'h0030, 16'h0032); req_q.delete();
    pulse_start(16'h0030, 16'h0032);
    drain(16, nu);
    check("slow_underrun_seen", {31'd0, nu > 0}, 32'd1);
    check_reqs(16'h0030, 3);

    // address wrap
    lat = 2; load_exp(16'hFFFF, 16'h0000); req_q.delete();
    pulse_start(16'hFFFF, 16'h0000);
    drain(16, nu);
    check_reqs(16'hFFFF, 2);

    // stop mid-block with a request outstanding
    lat = 10; done_cnt = 0;
    pulse_start(16'h0050, 16'h005F);
    repeat (13) @(negedge clk);
    pulse_irq();
    check("stop_pre_nibble", {28'd0, din}, 32'hC);
    check("stop_pre_cs", {31'd0, rom_cs}, 32'd1);
    pulse_stop();
    check("stop_cs", {31'd0, rom_cs}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_din", {28'd0, din}, 32'd0);
    inject_ok = 1'b1;
    @(negedge clk);
    inject_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("stop_late_ok_cs", {31'd0, rom_cs}, 32'd0);
    check("stop_late_ok_busy", {31'd0, busy}, 32'd0);
    pulse_irq();
    check("stop_irq_din", {28'd0, din}, 32'd0);
    check("stop_irq_underrun", {31'd0, underrun}, 32'd0);
    check("stop_no_done", done_cnt, 0);

    // restart while busy
    lat = 10;
    pulse_start(16'h0060, 16'h006F);
    repeat (3) @(negedge clk);
    check("restart_pre_cs", {31'd0, rom_cs}, 32'd1);
    load_exp(16'h0040, 16'h0041);
    pulse_start(16'h0040, 16'h0041);
    req_q.delete();
    check("restart_cs_gap", {31'd0, rom_cs}, 32'd0);
    @(negedge clk);
    check("restart_cs", {31'd0, rom_cs}, 32'd1);
    check("restart_addr", {16'd0, rom_addr}, 32'h0040);
    drain(16, nu);

    // asynchronous reset during a fetch
    lat = 40;
    pulse_start(16'h0070, 16'h0071);
    repeat (2) @(negedge clk);
    check("arst_pre_cs", {31'd0, rom_cs}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_cs", {31'd0, rom_cs}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_addr", {16'd0, rom_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_stays_idle", {31'd0, rom_cs}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
